factorial_regfile_ctrl: RTL and testbench

//  Initiator/controller on the two-entry 16-bit dual-port register file used by the factorial datapath.

---
 rtl/factorial_regfile_ctrl.sv | 163 ++++++++++++++++
 tb/tb_factorial_regfile_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/factorial_regfile_ctrl.sv
// Controller for a two-entry dual-port register file that computes N! with
// R0 as the accumulator and R1 as the down-counter, behind a START/DONE handshake.
module factorial_regfile_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DATA_W-1:0] N,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RESULT,
  output logic              OVF,
  output logic              WE1,
  output logic              WE2,
  output logic              WA1,
  output logic              WA2,
  output logic [DATA_W-1:0] W_DATA1,
  output logic [DATA_W-1:0] W_DATA2,
  output logic              REA1,
  output logic              REA2,
  output logic              RAA1,
  output logic              RAA2,
  input  logic [DATA_W-1:0] RDA1,
  input  logic [DATA_W-1:0] RDA2
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   n_q, n_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                ovf_q, ovf_d;
  logic [2*DATA_W-1:0] prod_s;

  // Full-width unsigned product of the captured operands; only the low half is written back.
  assign prod_s = {ZERO, acc_q} * {ZERO, cnt_q};

  assign WA1    = 1'b0;
  assign WA2    = 1'b1;
  assign RAA1   = 1'b0;
  assign RAA2   = 1'b1;
  assign RESULT = result_q;
  assign OVF    = ovf_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      n_q      <= ZERO;
      acc_q    <= ZERO;
      cnt_q    <= ZERO;
      result_q <= ZERO;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath update; RDA1/RDA2 are only looked at in READ.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          n_d     = N;
          state_d = S_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        ovf_d   = 1'b0;
        state_d = S_READ;
      end
      S_READ: begin
        acc_d = RDA1;
        cnt_d = RDA2;
        if (RDA2 <= ONE) begin
          result_d = RDA1;
          state_d  = S_DONE;
        end else begin
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (prod_s[2*DATA_W-1:DATA_W] != ZERO) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        state_d = S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore decode of the handshake and register-file controls.
  always_comb begin
    BUSY    = 1'b0;
    DONE    = 1'b0;
    WE1     = 1'b0;
    WE2     = 1'b0;
    W_DATA1 = ZERO;
    W_DATA2 = ZERO;
    REA1    = 1'b0;
    REA2    = 1'b0;
    case (state_q)
      S_INIT: begin
        BUSY    = 1'b1;
        WE1     = 1'b1;
        WE2     = 1'b1;
        W_DATA1 = ONE;
        W_DATA2 = n_q;
      end
      S_READ: begin
        BUSY = 1'b1;
        REA1 = 1'b1;
        REA2 = 1'b1;
      end
      S_WRITE: begin
        BUSY    = 1'b1;
        WE1     = 1'b1;
        WE2     = 1'b1;
        W_DATA1 = prod_s[DATA_W-1:0];
        W_DATA2 = cnt_q - ONE;
      end
      S_DONE: begin
        DONE = 1'b1;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_factorial_regfile_ctrl.sv
// Bench for factorial_regfile_ctrl: a behavioural register file closes the loop,
// and a scoreboard of expected results is consumed when DONE is seen.
module tb_factorial_regfile_ctrl;

  typedef struct {
    logic [15:0] result;
    logic        ovf;
    int          latency;
    int          writes;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] n;
  logic        busy, done, ovf;
  logic [15:0] result;
  logic        we1, we2, wa1, wa2, rea1, rea2, raa1, raa2;
  logic [15:0] w_data1, w_data2;
  wire  [15:0] rda1, rda2;
  logic [15:0] rf [0:1];

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb [$];

  factorial_regfile_ctrl #(.DATA_W(16)) dut (
    .CLK(clk), .RST(rst), .START(start), .N(n),
    .BUSY(busy), .DONE(done), .RESULT(result), .OVF(ovf),
    .WE1(we1), .WE2(we2), .WA1(wa1), .WA2(wa2),
    .W_DATA1(w_data1), .W_DATA2(w_data2),
    .REA1(rea1), .REA2(rea2), .RAA1(raa1), .RAA2(raa2),
    .RDA1(rda1), .RDA2(rda2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-entry register file: synchronous writes, combinational tri-state reads.
  always @(posedge clk) begin
    if (we1) rf[wa1] <= w_data1;
    if (we2) rf[wa2] <= w_data2;
  end
  assign rda1 = rea1 ? rf[raa1] : 16'bz;
  assign rda2 = rea2 ? rf[raa2] : 16'bz;

  function automatic exp_t model(input logic [15:0] nv);
    exp_t        e;
    logic [31:0] p;
    logic [15:0] acc;
    acc   = 16'd1;
    e.ovf = 1'b0;
    for (int c = int'(nv); c > 1; c--) begin
      p = {16'd0, acc} * 32'(c);
      if (p[31:16] != 16'd0) e.ovf = 1'b1;
      acc = p[15:0];
    end
    e.result  = acc;
    e.latency = 2 * ((nv <= 16'd1) ? 1 : int'(nv)) + 1;
    e.writes  = (nv <= 16'd1) ? 0 : int'(nv) - 1;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one computation starting from IDLE; ends one cycle after DONE (back in IDLE).
  task automatic run_op(input logic [15:0] nv, input int inject_cycle,
                        output int lat, output int writes, output logic seen,
                        output logic [15:0] res, output logic ovf_o,
                        output logic init_ok, output logic done_after);
    sb.push_back(model(nv));
    start = 1'b1;
    n     = nv;
    step();
    start   = 1'b0;
    n       = 16'hA5A5;
    lat     = 1;
    writes  = 0;
    seen    = 1'b0;
    res     = 16'hFFFF;
    ovf_o   = 1'bx;
    init_ok = busy && we1 && we2 && (w_data1 == 16'd1) && (w_data2 == nv) && !rea1 && !rea2;
    while (lat < 300) begin
      if (done) begin
        seen  = 1'b1;
        res   = result;
        ovf_o = ovf;
        break;
      end
      if (lat > 1 && we1 && we2) writes++;
      if (lat == inject_cycle) begin
        start = 1'b1;
        n     = 16'd2;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    step();
    done_after = done;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    n     = 16'd0;
    step();
    step();
    n_checks++;
    if ({busy, done, ovf, we1, we2, rea1, rea2} !== 7'd0 || result !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: ctl=%b result=%h, required ctl=0000000 result=0000",
               {busy, done, ovf, we1, we2, rea1, rea2}, result);
    end
    n_checks++;
    if ({wa1, wa2, raa1, raa2} !== 4'b0101) begin
      n_errors++;
      $display("FAIL reset_addrs: got %b, required 0101", {wa1, wa2, raa1, raa2});
    end
    rst = 1'b0;
    step();
  endtask

  // Covers a normal run, a wide run, an overflowing run and the run that follows it.
  task automatic test_factorial();
    logic [15:0] tbl [4] = '{16'd5, 16'd8, 16'd9, 16'd3};
    int lat, wr;
    logic seen, ov, iok, da;
    logic [15:0] res;
    exp_t e;
    foreach (tbl[i]) begin
      run_op(tbl[i], -1, lat, wr, seen, res, ov, iok, da);
      e = sb.pop_front();
      n_checks++;
      if (!seen || lat !== e.latency) begin
        n_errors++;
        $display("FAIL latency_n%0d: done_seen=%b cycle=%0d, required %0d", tbl[i], seen, lat, e.latency);
      end
      n_checks++;
      if (res !== e.result) begin
        n_errors++;
        $display("FAIL result_n%0d: got %h, required %h", tbl[i], res, e.result);
      end
      n_checks++;
      if (ov !== e.ovf) begin
        n_errors++;
        $display("FAIL ovf_n%0d: got %b, required %b", tbl[i], ov, e.ovf);
      end
      n_checks++;
      if (wr !== e.writes) begin
        n_errors++;
        $display("FAIL writes_n%0d: got %0d, required %0d", tbl[i], wr, e.writes);
      end
      n_checks++;
      if (iok !== 1'b1 || da !== 1'b0) begin
        n_errors++;
        $display("FAIL init_pulse_n%0d: init_ok=%b done_next=%b, required 1 and 0", tbl[i], iok, da);
      end
    end
  endtask

  task automatic test_small_n();
    logic [15:0] tbl [2] = '{16'd0, 16'd1};
    int lat, wr;
    logic seen, ov, iok, da;
    logic [15:0] res;
    exp_t e;
    foreach (tbl[i]) begin
      run_op(tbl[i], -1, lat, wr, seen, res, ov, iok, da);
      e = sb.pop_front();
      n_checks++;
      if (!seen || lat !== e.latency || lat !== 3) begin
        n_errors++;
        $display("FAIL small_latency_n%0d: cycle=%0d, required 3", tbl[i], lat);
      end
      n_checks++;
      if (res !== 16'd1 || ov !== 1'b0) begin
        n_errors++;
        $display("FAIL small_result_n%0d: got %h ovf=%b, required 0001 ovf=0", tbl[i], res, ov);
      end
      n_checks++;
      if (wr !== 0 || iok !== 1'b1) begin
        n_errors++;
        $display("FAIL small_writes_n%0d: writes=%0d init_ok=%b, required 0 and 1", tbl[i], wr, iok);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat, wr, extra;
    logic seen, ov, iok, da;
    logic [15:0] res;
    exp_t e;
    run_op(16'd6, 3, lat, wr, seen, res, ov, iok, da);
    e = sb.pop_front();
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      if (done || busy) extra++;
      step();
    end
    n_checks++;
    if (res !== 16'd720 || res !== e.result || lat !== e.latency) begin
      n_errors++;
      $display("FAIL busy_start_result: got %h at cycle %0d, required %h at %0d", res, lat, e.result, e.latency);
    end
    n_checks++;
    if (extra !== 0 || da !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_start_ignored: extra active cycles=%0d, required 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, wr, cyc;
    logic seen, ov, iok, da, found;
    logic [15:0] res, s0, s1;
    exp_t e;
    start = 1'b1;
    n     = 16'd7;
    step();
    start = 1'b0;
    cyc   = 1;
    found = 1'b0;
    while (cyc < 50 && !found) begin
      if (cyc > 3 && we1 && we2) found = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL reset_mid_find_write: no WRITE cycle within %0d cycles, required one", cyc);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, ovf, we1, we2, rea1, rea2} !== 7'd0 || result !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs: ctl=%b result=%h, required 0000000 and 0000",
               {busy, done, ovf, we1, we2, rea1, rea2}, result);
    end
    s0 = rf[0];
    s1 = rf[1];
    step();
    n_checks++;
    if (rf[0] !== s0 || rf[1] !== s1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_no_writes: rf=%h/%h busy=%b, required %h/%h busy=0", rf[0], rf[1], busy, s0, s1);
    end
    run_op(16'd4, -1, lat, wr, seen, res, ov, iok, da);
    e = sb.pop_front();
    n_checks++;
    if (res !== 16'd24 || res !== e.result || ov !== 1'b0 || lat !== e.latency) begin
      n_errors++;
      $display("FAIL reset_mid_rerun: got %h ovf=%b cycle=%0d, required 0018 ovf=0 cycle=%0d", res, ov, lat, e.latency);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    n     = 16'd0;
    test_reset();
    test_factorial();
    test_small_n();
    test_start_while_busy();
    test_reset_mid_run();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
